// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Arbitrates the single register-file write port of the single-cycle core
//   between execute-stage results (ALU, PC+4, LUI immediate) and late load
//   responses from data memory.  At most one load is outstanding.  Execute
//   is stalled only when the port is taken by a load response, when a second
//   load is presented, or on a WAW hazard against the pending load's rd.
//   A load with no response for LD_TIMEOUT wait cycles is aborted and
//   reported with a one-cycle o_ld_err pulse.
//
// Parameters:
//   LD_TIMEOUT  wait cycles without a response before abort (>= 2)
//
// Ports:
//   i_clk            clock, all state on rising edge
//   i_rst            synchronous reset, active-high
//   i_ex_valid       execute-stage instruction present
//   o_ex_ready       execute request accepted this cycle (combinational)
//   i_ex_is_load     instruction is a load (writes later via load response)
//   i_ex_rd_select   00 ALU, 01 PC+4, 10 LUI, 11 ALU
//   i_ex_rd          destination register
//   i_ex_alu         ALU result
//   i_ex_pc          instruction PC
//   i_ex_lui_imm     LUI immediate, already shifted
//   i_ld_resp_valid  load data valid this cycle
//   i_ld_resp_data   load data
//   o_rf_we          register-file write enable (registered)
//   o_rf_waddr       register-file write address (registered)
//   o_rf_wdata       register-file write data (registered)
//   o_ld_pending     high while waiting for a load response
//   o_ld_err         one-cycle pulse on load timeout
//   o_stall_cnt      saturating count of stalled execute cycles
//                    (present only when WB_STATS_EN is defined)
//
// Build option:
//   WB_STATS_EN  adds o_stall_cnt and its counter
//
// FSM states:
//   state       | meaning
//   ST_IDLE     | no load outstanding, execute always accepted
//   ST_LD_WAIT  | one load outstanding, waiting for its response
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int LD_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ex_valid,
  output logic        o_ex_ready,
  input  logic        i_ex_is_load,
  input  logic [1:0]  i_ex_rd_select,
  input  logic [4:0]  i_ex_rd,
  input  logic [31:0] i_ex_alu,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_lui_imm,
  input  logic        i_ld_resp_valid,
  input  logic [31:0] i_ld_resp_data,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic        o_ld_pending,
  output logic        o_ld_err
`ifdef WB_STATS_EN
  ,
  output logic [15:0] o_stall_cnt
`endif
);

  localparam int TW = (LD_TIMEOUT > 2) ? $clog2(LD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(LD_TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_LD_WAIT = 1'b1
  } state_t;

  state_t        r_state;
  logic [4:0]    r_pend_rd;
  logic [TW-1:0] r_timer;
  logic          r_rf_we;
  logic [4:0]    r_rf_waddr;
  logic [31:0]   r_rf_wdata;
  logic          r_ld_err;

  logic          w_waw;
  logic          w_ex_ready;
  logic          w_accept;
  logic [31:0]   w_ex_wdata;

  // WAW only matters for a real register; x0 loads never write anyway.
  assign w_waw = (i_ex_rd == r_pend_rd) && (i_ex_rd != 5'd0);

  always_comb begin
    w_ex_ready = 1'b1;
    if (r_state == ST_LD_WAIT) begin
      w_ex_ready = !(i_ld_resp_valid || i_ex_is_load || w_waw);
    end
  end

  assign w_accept = i_ex_valid && w_ex_ready;

  always_comb begin
    w_ex_wdata = i_ex_alu;
    case (i_ex_rd_select)
      2'b01:   w_ex_wdata = i_ex_pc + 32'd4;
      2'b10:   w_ex_wdata = i_ex_lui_imm;
      default: w_ex_wdata = i_ex_alu;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_pend_rd  <= 5'd0;
      r_timer    <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= 32'd0;
      r_ld_err   <= 1'b0;
    end else begin
      r_rf_we  <= 1'b0;
      r_ld_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Responses seen here are stray or belong to an aborted load.
          if (w_accept) begin
            if (i_ex_is_load) begin
              r_pend_rd <= i_ex_rd;
              r_timer   <= '0;
              r_state   <= ST_LD_WAIT;
            end else if (i_ex_rd != 5'd0) begin
              r_rf_we    <= 1'b1;
              r_rf_waddr <= i_ex_rd;
              r_rf_wdata <= w_ex_wdata;
            end
          end
        end
        ST_LD_WAIT: begin
          if (i_ld_resp_valid) begin
            // Response owns the port; execute is held off by w_ex_ready.
            if (r_pend_rd != 5'd0) begin
              r_rf_we    <= 1'b1;
              r_rf_waddr <= r_pend_rd;
              r_rf_wdata <= i_ld_resp_data;
            end
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else begin
            // Only non-loads can be accepted here.
            if (w_accept && (i_ex_rd != 5'd0)) begin
              r_rf_we    <= 1'b1;
              r_rf_waddr <= i_ex_rd;
              r_rf_wdata <= w_ex_wdata;
            end
            if (r_timer == TMR_LAST) begin
              // pend_rd is intentionally left as-is on abort.
              r_ld_err <= 1'b1;
              r_timer  <= '0;
              r_state  <= ST_IDLE;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ex_ready   = w_ex_ready;
  assign o_rf_we      = r_rf_we;
  assign o_rf_waddr   = r_rf_waddr;
  assign o_rf_wdata   = r_rf_wdata;
  assign o_ld_pending = (r_state == ST_LD_WAIT);
  assign o_ld_err     = r_ld_err;

`ifdef WB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= 16'd0;
    end else if (i_ex_valid && !w_ex_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int LD_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_load;
  logic [1:0]  ex_sel;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ld_pending;
  logic        ld_err;
`ifdef WB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter #(.LD_TIMEOUT(LD_TIMEOUT)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_ex_valid     (ex_valid),
    .o_ex_ready     (ex_ready),
    .i_ex_is_load   (ex_is_load),
    .i_ex_rd_select (ex_sel),
    .i_ex_rd        (ex_rd),
    .i_ex_alu       (ex_alu),
    .i_ex_pc        (ex_pc),
    .i_ex_lui_imm   (ex_imm),
    .i_ld_resp_valid(resp_valid),
    .i_ld_resp_data (resp_data),
    .o_rf_we        (rf_we),
    .o_rf_waddr     (rf_waddr),
    .o_rf_wdata     (rf_wdata),
    .o_ld_pending   (ld_pending),
    .o_ld_err       (ld_err)
`ifdef WB_STATS_EN
    ,
    .o_stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input bit v, input bit l, input logic [1:0] s, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                        input bit rv, input logic [31:0] rdat);
    ex_valid   = v;
    ex_is_load = l;
    ex_sel     = s;
    ex_rd      = rd;
    ex_alu     = alu;
    ex_pc      = pc;
    ex_imm     = imm;
    resp_valid = rv;
    resp_data  = rdat;
  endtask

  // One full cycle: drive at negedge, sample registered outputs 1 ns after posedge.
  task automatic cyc(input bit v, input bit l, input logic [1:0] s, input logic [4:0] rd,
                     input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                     input bit rv, input logic [31:0] rdat);
    @(negedge clk);
    set_in(v, l, s, rd, alu, pc, imm, rv, rdat);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          v;
    bit          l;
    logic [1:0]  s;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] imm;
    bit          rv;
    logic [31:0] rdat;
    bit          e_ready;
    bit          e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    bit          e_pend;
  } vec_t;

  function automatic vec_t mk(bit v, bit l, logic [1:0] s, logic [4:0] rd, logic [31:0] alu,
                              logic [31:0] pc, logic [31:0] imm, bit rv, logic [31:0] rdat,
                              bit er, bit ew, logic [4:0] ea, logic [31:0] ed, bit ep);
    vec_t t;
    t.v = v; t.l = l; t.s = s; t.rd = rd; t.alu = alu; t.pc = pc; t.imm = imm;
    t.rv = rv; t.rdat = rdat; t.e_ready = er; t.e_we = ew; t.e_waddr = ea;
    t.e_wdata = ed; t.e_pend = ep;
    return t;
  endfunction

  vec_t tbl[19];

  // ---------------- behavioural reference model ----------------
  bit          m_pend;
  logic [4:0]  m_prd;
  int          m_age;
  bit          m_ready;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_err;
  int          m_stall;

  function automatic logic [31:0] result_of(logic [1:0] s, logic [31:0] alu,
                                            logic [31:0] pc, logic [31:0] imm);
    if (s == 2'd1) return pc + 32'd4;
    if (s == 2'd2) return imm;
    return alu;
  endfunction

  task automatic model_step();
    bit was_pend;
    m_we  = 0;
    m_err = 0;
    if (rst) begin
      m_pend = 0; m_prd = 0; m_age = 0; m_stall = 0;
      m_waddr = 0; m_wdata = 0; m_ready = 1;
      return;
    end
    was_pend = m_pend;
    m_ready = !m_pend || !(resp_valid || ex_is_load || (ex_rd == m_prd && ex_rd != 0));
    if (ex_valid && !m_ready && m_stall < 65535) m_stall++;
    if (was_pend && resp_valid) begin
      if (m_prd != 0) begin m_we = 1; m_waddr = m_prd; m_wdata = resp_data; end
      m_pend = 0;
    end else begin
      if (ex_valid && m_ready) begin
        if (ex_is_load) begin
          m_pend = 1; m_prd = ex_rd; m_age = 0;
        end else if (ex_rd != 0) begin
          m_we = 1; m_waddr = ex_rd; m_wdata = result_of(ex_sel, ex_alu, ex_pc, ex_imm);
        end
      end
      if (was_pend) begin
        m_age++;
        if (m_age == LD_TIMEOUT) begin m_err = 1; m_pend = 0; end
      end
    end
  endtask

  initial begin
    tbl[0]  = mk(1,0,2'd0,5'd5, 32'h1234,32'h0,32'h0,        0,32'h0,    1,1,5'd5,32'h1234,    0);
    tbl[1]  = mk(1,0,2'd1,5'd1, 32'h0,32'hFFFFFFFC,32'h0,    0,32'h0,    1,1,5'd1,32'h0,       0);
    tbl[2]  = mk(1,0,2'd2,5'd2, 32'h0,32'h0,32'hABCDE000,    0,32'h0,    1,1,5'd2,32'hABCDE000,0);
    tbl[3]  = mk(1,0,2'd3,5'd6, 32'h55,32'h100,32'h200,      0,32'h0,    1,1,5'd6,32'h55,      0);
    tbl[4]  = mk(1,0,2'd0,5'd0, 32'h99,32'h0,32'h0,          0,32'h0,    1,0,5'd0,32'h0,       0);
    tbl[5]  = mk(1,1,2'd0,5'd7, 32'hBAD,32'h0,32'h0,         0,32'h0,    1,0,5'd0,32'h0,       1);
    tbl[6]  = mk(1,0,2'd0,5'd3, 32'h33,32'h0,32'h0,          0,32'h0,    1,1,5'd3,32'h33,      1);
    tbl[7]  = mk(1,0,2'd0,5'd7, 32'h77,32'h0,32'h0,          0,32'h0,    0,0,5'd0,32'h0,       1);
    tbl[8]  = mk(1,0,2'd0,5'd7, 32'h77,32'h0,32'h0,          1,32'hDEAD, 0,1,5'd7,32'hDEAD,    0);
    tbl[9]  = mk(1,0,2'd0,5'd7, 32'h77,32'h0,32'h0,          0,32'h0,    1,1,5'd7,32'h77,      0);
    tbl[10] = mk(1,1,2'd0,5'd8, 32'h0,32'h0,32'h0,           0,32'h0,    1,0,5'd0,32'h0,       1);
    tbl[11] = mk(1,0,2'd0,5'd4, 32'h44,32'h0,32'h0,          1,32'hBEEF, 0,1,5'd8,32'hBEEF,    0);
    tbl[12] = mk(1,0,2'd0,5'd4, 32'h44,32'h0,32'h0,          0,32'h0,    1,1,5'd4,32'h44,      0);
    tbl[13] = mk(1,1,2'd0,5'd0, 32'h0,32'h0,32'h0,           0,32'h0,    1,0,5'd0,32'h0,       1);
    tbl[14] = mk(1,0,2'd0,5'd0, 32'h5,32'h0,32'h0,           0,32'h0,    1,0,5'd0,32'h0,       1);
    tbl[15] = mk(1,1,2'd0,5'd9, 32'h0,32'h0,32'h0,           0,32'h0,    0,0,5'd0,32'h0,       1);
    tbl[16] = mk(0,0,2'd0,5'd0, 32'h0,32'h0,32'h0,           1,32'h1111, 0,0,5'd0,32'h0,       0);
    tbl[17] = mk(0,0,2'd0,5'd0, 32'h0,32'h0,32'h0,           1,32'h2222, 0,0,5'd0,32'h0,       0);
    tbl[18] = mk(1,0,2'd1,5'd10,32'h0,32'h100,32'h0,         0,32'h0,    1,1,5'd10,32'h104,    0);

    // ---------------- reset ----------------
    rst = 1;
    set_in(0, 0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_we",      rf_we,      0);
    check("reset_waddr",   rf_waddr,   0);
    check("reset_wdata",   rf_wdata,   0);
    check("reset_pending", ld_pending, 0);
    check("reset_err",     ld_err,     0);
    @(negedge clk);
    rst = 0;

    // ---------------- table ----------------
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      set_in(tbl[i].v, tbl[i].l, tbl[i].s, tbl[i].rd, tbl[i].alu, tbl[i].pc, tbl[i].imm,
             tbl[i].rv, tbl[i].rdat);
      #1;
      if (tbl[i].v) check($sformatf("tbl%0d_ready", i), ex_ready, tbl[i].e_ready);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_we", i), rf_we, tbl[i].e_we);
      if (tbl[i].e_we) begin
        check($sformatf("tbl%0d_waddr", i), rf_waddr, tbl[i].e_waddr);
        check($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].e_wdata);
      end
      check($sformatf("tbl%0d_pending", i), ld_pending, tbl[i].e_pend);
      check($sformatf("tbl%0d_err", i), ld_err, 0);
    end

    // ---------------- timeout, then late response ignored ----------------
    cyc(1, 1, 2'd0, 5'd9, 32'd0, 32'd0, 32'd0, 0, 32'd0);
    for (int k = 1; k < LD_TIMEOUT; k++) begin
      idle_cyc();
      check($sformatf("to_wait%0d_pending", k), ld_pending, 1);
      check($sformatf("to_wait%0d_err", k), ld_err, 0);
    end
    idle_cyc();
    check("to_err",     ld_err,     1);
    check("to_pending", ld_pending, 0);
    check("to_we",      rf_we,      0);
    cyc(0, 0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1, 32'hAAAA);
    check("to_late_we",  rf_we,  0);
    check("to_err_once", ld_err, 0);

    // ---------------- response on the last wait cycle wins ----------------
    cyc(1, 1, 2'd0, 5'd11, 32'd0, 32'd0, 32'd0, 0, 32'd0);
    for (int k = 1; k < LD_TIMEOUT; k++) idle_cyc();
    cyc(0, 0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1, 32'h0B0B);
    check("edge_we",      rf_we,      1);
    check("edge_waddr",   rf_waddr,   11);
    check("edge_wdata",   rf_wdata,   32'h0B0B);
    check("edge_err",     ld_err,     0);
    check("edge_pending", ld_pending, 0);

    // ---------------- reset during LD_WAIT ----------------
    cyc(1, 0, 2'd0, 5'd13, 32'h1313, 32'd0, 32'd0, 0, 32'd0);
    cyc(1, 1, 2'd0, 5'd12, 32'd0, 32'd0, 32'd0, 0, 32'd0);
    check("rstw_pending_before", ld_pending, 1);
    @(negedge clk);
    rst = 1;
    set_in(0, 0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 32'd0);
    @(posedge clk);
    #1;
    check("rstw_we",      rf_we,      0);
    check("rstw_waddr",   rf_waddr,   0);
    check("rstw_wdata",   rf_wdata,   0);
    check("rstw_pending", ld_pending, 0);
    check("rstw_err",     ld_err,     0);
    @(negedge clk);
    rst = 0;
    cyc(0, 0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1, 32'hCCCC);
    check("rstw_resp_ignored", rf_we, 0);

    // ---------------- randomized against the model ----------------
    @(negedge clk);
    rst = 1;
    model_step();
    @(posedge clk);
    #1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      set_in($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 25,
             2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom, ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom, $urandom,
             $urandom_range(0, 99) < 30, $urandom);
      model_step();
      #1;
      if (!rst && ex_valid) check($sformatf("rnd%0d_ready", n), ex_ready, m_ready);
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_we", n), rf_we, m_we);
      if (m_we) begin
        check($sformatf("rnd%0d_waddr", n), rf_waddr, m_waddr);
        check($sformatf("rnd%0d_wdata", n), rf_wdata, m_wdata);
      end
      check($sformatf("rnd%0d_err", n), ld_err, m_err);
      check($sformatf("rnd%0d_pending", n), ld_pending, m_pend);
    end
`ifdef WB_STATS_EN
    check("stall_cnt", stall_cnt, 32'(m_stall));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
